pu_msp430_clock_switch_ctrl: RTL and testbench

//  Sequencer that drives the selection input of the glitch-free clock mux from the mclk domain.
//  On a switch request it wakes the alternate oscillator (clk_in1 source) and waits for it to be stable.
//  It then flips mux_sel and holds busy until the mux's two-stage handover has settled.
//  It also falls back to source 0 when the alternate oscillator is lost.

---
 rtl/pu_msp430_clock_switch_ctrl_pkg.sv | 10 +
 rtl/pu_msp430_clock_switch_ctrl_if.sv | 23 ++
 rtl/pu_msp430_clock_switch_ctrl.sv | 113 +++++++++++
 tb/tb_pu_msp430_clock_switch_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_msp430_clock_switch_ctrl_pkg.sv
// Shared types for the MSP430 clock-switch sequencer.
package pu_msp430_clock_switch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAKE,
    SWITCH
  } clk_sw_state_t;

endpackage

// File: rtl/pu_msp430_clock_switch_ctrl_if.sv
// Request handshake and clock-mux control signals of the clock-switch sequencer.
interface pu_msp430_clock_switch_ctrl_if;
  logic req_valid;
  logic req_sel;
  logic req_ready;
  logic osc1_stable;
  logic osc1_en;
  logic mux_sel;
  logic cur_sel;
  logic busy;
  logic done;
  logic err;

  modport master (
    output req_valid, req_sel, osc1_stable,
    input  req_ready, osc1_en, mux_sel, cur_sel, busy, done, err
  );

  modport slave (
    input  req_valid, req_sel, osc1_stable,
    output req_ready, osc1_en, mux_sel, cur_sel, busy, done, err
  );
endinterface

// File: rtl/pu_msp430_clock_switch_ctrl.sv
// Drives the glitch-free clock mux select from mclk: wakes osc1, flips mux_sel, waits for
// the mux handover to settle, and falls back to source 0 when osc1 is lost.
module pu_msp430_clock_switch_ctrl
  import pu_msp430_clock_switch_ctrl_pkg::*;
#(
  parameter int unsigned OSC_WAKE_CYCLES = 64,
  parameter int unsigned SWITCH_CYCLES   = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input logic                            mclk,
  input logic                            puc_rst,
  pu_msp430_clock_switch_ctrl_if.slave   sw
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  clk_sw_state_t    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             osc1_en_q;
  logic             mux_sel_q;
  logic             cur_sel_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             loss;
  logic [CNT_W-1:0] cnt_inc;

  assign loss          = cur_sel_q & ~sw.osc1_stable;
  assign sw.req_ready  = (state_q == IDLE) & ~loss;
  // Saturating so a long stay in one state never wraps the counter.
  assign cnt_inc       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      osc1_en_q <= 1'b0;
      mux_sel_q <= 1'b0;
      cur_sel_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Oscillator loss takes priority over any request in the same cycle.
          if (loss) begin
            state_q   <= SWITCH;
            mux_sel_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            err_q     <= 1'b1;
          end else if (sw.req_valid) begin
            if (sw.req_sel == cur_sel_q) begin
              done_q <= 1'b1;
            end else if (sw.req_sel) begin
              state_q   <= WAKE;
              osc1_en_q <= 1'b1;
              cnt_q     <= '0;
              busy_q    <= 1'b1;
            end else begin
              state_q   <= SWITCH;
              mux_sel_q <= 1'b0;
              cnt_q     <= '0;
              busy_q    <= 1'b1;
            end
          end
        end
        WAKE: begin
          if ((cnt_q >= CNT_W'(OSC_WAKE_CYCLES - 1)) && sw.osc1_stable) begin
            state_q   <= SWITCH;
            mux_sel_q <= 1'b1;
            cnt_q     <= '0;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= IDLE;
            osc1_en_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        SWITCH: begin
          if (cnt_q == CNT_W'(SWITCH_CYCLES - 1)) begin
            state_q   <= IDLE;
            cur_sel_q <= mux_sel_q;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            if (!mux_sel_q) begin
              osc1_en_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sw.osc1_en = osc1_en_q;
  assign sw.mux_sel = mux_sel_q;
  assign sw.cur_sel = cur_sel_q;
  assign sw.busy    = busy_q;
  assign sw.done    = done_q;
  assign sw.err     = err_q;

endmodule

// File: tb/tb_pu_msp430_clock_switch_ctrl.sv
// Directed bench for the clock-switch sequencer; outputs are compared as the packed vector
// {osc1_en, mux_sel, cur_sel, busy, done, err}.
module tb_pu_msp430_clock_switch_ctrl;

  logic mclk;
  logic puc_rst;
  int   checks;
  int   errors;

  pu_msp430_clock_switch_ctrl_if sw ();

  pu_msp430_clock_switch_ctrl #(
    .OSC_WAKE_CYCLES (64),
    .SWITCH_CYCLES   (8),
    .TIMEOUT_CYCLES  (1024)
  ) dut (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .sw      (sw.slave)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  function automatic logic [5:0] outs();
    return {sw.osc1_en, sw.mux_sel, sw.cur_sel, sw.busy, sw.done, sw.err};
  endfunction

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  // Drives req_valid for cycle N and returns 1 ns into cycle N+1 with req_valid low.
  task automatic req(input logic sel);
    sw.req_valid = 1'b1;
    sw.req_sel   = sel;
    step();
    sw.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    puc_rst        = 1'b1;
    sw.req_valid   = 1'b1;
    sw.req_sel     = 1'b1;
    sw.osc1_stable = 1'b0;
    step();
    step();
    exp = 6'b000000;
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL reset_outs: got %b expected %b", outs(), exp);
    end
    sw.req_valid = 1'b0;
    puc_rst      = 1'b0;
    step();
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL reset_release_outs: got %b expected %b", outs(), exp);
    end
    checks++;
    if (sw.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", sw.req_ready);
    end
  endtask

  task automatic test_switch_up();
    logic [5:0] exp;
    sw.osc1_stable = 1'b1;
    sw.req_valid   = 1'b1;
    sw.req_sel     = 1'b1;
    #1;
    checks++;
    if (sw.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL up_ready: got %b expected 1", sw.req_ready);
    end
    step();
    sw.req_valid = 1'b0;
    for (int c = 1; c <= 74; c++) begin
      exp = {1'b1, c >= 65, c >= 73, c < 73, c == 73, 1'b0};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL up_cycle%0d: got %b expected %b", c, outs(), exp);
      end
      if (c == 1) begin
        checks++;
        if (sw.req_ready !== 1'b0) begin
          errors++;
          $display("FAIL up_busy_ready: got %b expected 0", sw.req_ready);
        end
      end
      // A request during WAKE must be dropped.
      sw.req_valid = (c == 10);
      sw.req_sel   = 1'b0;
      step();
    end
    sw.req_valid = 1'b0;
  endtask

  task automatic test_same_sel();
    logic [5:0] exp;
    req(1'b1);
    for (int c = 1; c <= 2; c++) begin
      exp = {1'b1, 1'b1, 1'b1, 1'b0, c == 1, 1'b0};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL same_cycle%0d: got %b expected %b", c, outs(), exp);
      end
      step();
    end
  endtask

  task automatic test_switch_down();
    logic [5:0] exp;
    req(1'b0);
    for (int c = 1; c <= 10; c++) begin
      exp = {c < 9, 1'b0, c < 9, c < 9, c == 9, 1'b0};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL down_cycle%0d: got %b expected %b", c, outs(), exp);
      end
      step();
    end
  endtask

  task automatic test_late_stable();
    logic [5:0] exp;
    sw.osc1_stable = 1'b0;
    req(1'b1);
    for (int c = 1; c <= 110; c++) begin
      exp = {1'b1, c >= 101, c >= 109, c < 109, c == 109, 1'b0};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL late_cycle%0d: got %b expected %b", c, outs(), exp);
      end
      if (c == 100) sw.osc1_stable = 1'b1;
      step();
    end
  endtask

  task automatic test_loss();
    logic [5:0] exp;
    sw.osc1_stable = 1'b0;
    sw.req_valid   = 1'b1;
    sw.req_sel     = 1'b0;
    #1;
    checks++;
    if (sw.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL loss_ready: got %b expected 0", sw.req_ready);
    end
    step();
    sw.req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      exp = {c < 9, 1'b0, c < 9, c < 9, c == 9, c == 1};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL loss_cycle%0d: got %b expected %b", c, outs(), exp);
      end
      step();
    end
  endtask

  task automatic test_timeout();
    logic [5:0] exp;
    sw.osc1_stable = 1'b0;
    req(1'b1);
    for (int c = 1; c <= 1026; c++) begin
      exp = {c <= 1024, 1'b0, 1'b0, c <= 1024, 1'b0, c == 1025};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL timeout_cycle%0d: got %b expected %b", c, outs(), exp);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp;
    sw.osc1_stable = 1'b1;
    req(1'b1);
    repeat (9) step();
    exp = 6'b100100;
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL mid_wake_pre: got %b expected %b", outs(), exp);
    end
    puc_rst = 1'b1;
    step();
    puc_rst = 1'b0;
    exp = 6'b000000;
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL mid_wake_rst: got %b expected %b", outs(), exp);
    end
    step();
    req(1'b1);
    repeat (69) step();
    exp = 6'b110100;
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL mid_switch_pre: got %b expected %b", outs(), exp);
    end
    puc_rst = 1'b1;
    step();
    puc_rst = 1'b0;
    exp = 6'b000000;
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL mid_switch_rst: got %b expected %b", outs(), exp);
    end
    checks++;
    if (sw.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_switch_ready: got %b expected 1", sw.req_ready);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    puc_rst        = 1'b1;
    sw.req_valid   = 1'b0;
    sw.req_sel     = 1'b0;
    sw.osc1_stable = 1'b0;
    test_reset();
    test_switch_up();
    test_same_sel();
    test_switch_down();
    test_late_stable();
    test_loss();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
